// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo
//   Captures processor register-writeback events into a small FIFO so a
//   trace consumer can drain them at its own pace. When the FIFO is full and
//   nothing is popped, the event is dropped. The drop is recorded in a sticky
//   overflow flag and in a saturating 8-bit drop counter.
//
//   Optional build macro: WB_TRACE_ZERO_FILTER_EN
//     When defined, writebacks to register 0 are not treated as events.
//     When undefined, they are captured like any other write.
//
// Parameters
//   DEPTH  - entry count, power of two in 2..64
//   CNT_W  - occupancy width, log2(DEPTH)+1
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-low reset
//   wb_valid  in   writeback event this cycle
//   wb_reg    in   [4:0]  destination register
//   wb_data   in   [31:0] value written
//   wb_pc     in   [31:0] PC of the writing instruction
//   out_valid out  head entry available
//   out_ready in   consumer accepts the head entry
//   out_reg   out  [4:0]  head register
//   out_data  out  [31:0] head data
//   out_pc    out  [31:0] head PC
//   count     out  [CNT_W-1:0] occupancy
//   full      out  count == DEPTH
//   overflow  out  sticky, at least one event dropped
//   drop_cnt  out  [7:0] dropped events, saturating at 255
module wb_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic [4:0]       wb_reg,
    input  logic [31:0]      wb_data,
    input  logic [31:0]      wb_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_reg,
    output logic [31:0]      out_data,
    output logic [31:0]      out_pc,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             overflow,
    output logic [7:0]       drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]  rg;
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_q, drop_d;

    logic event_w, push_w, pop_w, drop_w, full_w, empty_w;

    // Event qualification. The register-0 filter removes the event entirely,
    // so a filtered write can neither push nor count as a drop.
    always_comb begin
`ifdef WB_TRACE_ZERO_FILTER_EN
        event_w = wb_valid && (wb_reg != 5'd0);
`else
        event_w = wb_valid;
`endif
    end

    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign empty_w = (count_q == '0);
    assign pop_w   = !empty_w && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push_w  = event_w && (!full_w || pop_w);
    assign drop_w  = event_w && full_w && !pop_w;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        // Pointers are exactly AW bits wide, so +1 wraps modulo DEPTH.
        if (push_w) wptr_d = wptr_q + 1'b1;
        if (pop_w)  rptr_d = rptr_q + 1'b1;

        unique case ({push_w, pop_w})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop_w) begin
            overflow_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Storage has no reset; entries are only observable while count != 0.
    always_ff @(posedge clk) begin
        if (rst && push_w) begin
            mem_q[wptr_q] <= '{rg: wb_reg, data: wb_data, pc: wb_pc};
        end
    end

    // Head fields come straight from storage (no write-through bypass).
    // A new entry is therefore visible one cycle after it is pushed.
    assign out_valid = !empty_w;
    assign out_reg   = mem_q[rptr_q].rg;
    assign out_data  = mem_q[rptr_q].data;
    assign out_pc    = mem_q[rptr_q].pc;
    assign count     = count_q;
    assign full      = full_w;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
module tb_wb_trace_fifo;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             wb_valid;
    logic [4:0]       wb_reg;
    logic [31:0]      wb_data;
    logic [31:0]      wb_pc;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_reg;
    logic [31:0]      out_data;
    logic [31:0]      out_pc;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             overflow;
    logic [7:0]       drop_cnt;

    wb_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_pc(wb_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_reg(out_reg), .out_data(out_data), .out_pc(out_pc),
        .count(count), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: accepted events as a queue, plus drop bookkeeping.
    typedef struct {
        logic [4:0]  rg;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    ent_t exp_q[$];
    bit   m_ovf  = 1'b0;
    int   m_drop = 0;

    // Monitor: on the falling edge the DUT reflects the previous rising
    // edge; compare, then advance the model with the inputs that the next
    // rising edge will sample.
    always @(negedge clk) begin
        bit ev, pop, room;
        chk("count",     32'(count),     32'(exp_q.size()));
        chk("full",      32'(full),      32'(exp_q.size() == DEPTH));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
        if (exp_q.size() != 0) begin
            chk("out_reg",  32'(out_reg), 32'(exp_q[0].rg));
            chk("out_data", out_data,     exp_q[0].data);
            chk("out_pc",   out_pc,       exp_q[0].pc);
        end

        if (!rst) begin
            exp_q.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            ev = wb_valid;
`ifdef WB_TRACE_ZERO_FILTER_EN
            if (wb_reg == 5'd0) ev = 1'b0;
`endif
            pop  = (exp_q.size() != 0) && out_ready;
            room = (exp_q.size() < DEPTH) || pop;
            if (pop) void'(exp_q.pop_front());
            if (ev && room) begin
                exp_q.push_back('{rg: wb_reg, data: wb_data, pc: wb_pc});
            end else if (ev) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
    end

    int pc_seq = 0;

    // Apply inputs, then return 2 time units after the rising edge that
    // sampled them.
    task automatic drive(input logic r, input logic v, input logic [4:0] rg,
                         input logic [31:0] d, input logic rdy);
        rst       = r;
        wb_valid  = v;
        wb_reg    = rg;
        wb_data   = d;
        wb_pc     = 32'(pc_seq) << 2;
        out_ready = rdy;
        pc_seq++;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b1, 1'b0, 5'd0, 32'd0, rdy);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic fill_full();
        for (int i = 1; i <= DEPTH; i++) drive(1'b1, 1'b1, 5'(i), $urandom, 1'b0);
    endtask

    task automatic drain();
        int k = 0;
        while (out_valid && k < 40) begin
            idle(1'b1);
            k++;
        end
        chk("drain_bound", 32'(out_valid), 32'd0);
    endtask

    initial begin
        do_reset();
        do_reset();

        // Single entry: visible next cycle, held while not accepted.
        rst = 1'b1; wb_valid = 1'b1; wb_reg = 5'd8; wb_data = 32'h5; wb_pc = 32'h4;
        out_ready = 1'b0;
        @(posedge clk); #2;
        repeat (4) idle(1'b0);
        drain();

        // Fill then drain in order.
        fill_full();
        idle(1'b0);
        chk("full_after_fill", 32'(full), 32'd1);
        drain();

        // Overflow while full.
        fill_full();
        repeat (3) drive(1'b1, 1'b1, 5'd9, $urandom, 1'b0);
        idle(1'b0);
        chk("drop_cnt_3", 32'(drop_cnt), 32'd3);

        // Simultaneous push and pop while full, then pointer wrap.
        drive(1'b1, 1'b1, 5'd10, $urandom, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 5'(11 + i), $urandom, 1'b1);
        drain();

        // Reset discards queued entries even with an event present.
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 5'(i + 1), $urandom, 1'b0);
        drive(1'b0, 1'b1, 5'd7, $urandom, 1'b1);
        idle(1'b0);
        chk("count_after_rst", 32'(count), 32'd0);

        // Register 0 write.
        drive(1'b1, 1'b1, 5'd0, 32'hABCD, 1'b0);
        idle(1'b0);
        drain();

        // Drop counter saturation.
        do_reset();
        fill_full();
        repeat (260) drive(1'b1, 1'b1, 5'd3, $urandom, 1'b0);
        idle(1'b0);
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 99) < 60),
                  (($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom)),
                  $urandom,
                  ($urandom_range(0, 99) < 45));
        end
        drain();
        idle(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_trace_fifo.md
WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count (power of two, 2..64).
REQ-002 SHALL have parameter CNT_W, default 4, width of occupancy count (log2(DEPTH)+1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port wb_valid  input  1  processor writeback event (RegWrite) this cycle.
REQ-006 SHALL have port wb_reg  input  5  destination register number.
REQ-007 SHALL have port wb_data  input  32  value written.
REQ-008 SHALL have port wb_pc  input  32  PC of the writing instruction.
REQ-009 SHALL have port out_valid  output  1  head entry available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-011 SHALL have port out_reg / out_data / out_pc  output  5/32/32  head entry fields.
REQ-012 SHALL have port count  output  CNT_W  current occupancy.
REQ-013 SHALL have port full  output  1  count == DEPTH.
REQ-014 SHALL have port overflow  output  1  sticky: at least one event dropped.
REQ-015 SHALL have port drop_cnt  output  8  dropped events, saturating at 255.

Function
REQ-016 SHALL push {wb_reg, wb_data, wb_pc} when wb_valid=1 and (full=0 or pop this cycle).
REQ-017 SHALL pop when out_valid=1 and out_ready=1; head advances on that edge.
REQ-018 SHALL drive out_valid = (count != 0); head fields driven from storage, no input-to-output bypass.
REQ-019 SHALL give push-to-out_valid latency of exactly one cycle when empty.
REQ-020 SHALL, on simultaneous push and pop, keep count unchanged, including when full.
REQ-021 SHALL, with wb_valid=1 while full and no pop, drop the event, set overflow=1, increment drop_cnt unless 255.
REQ-022 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-023 SHALL use read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH without skipped or duplicated entries.
REQ-024 SHALL preserve event order; output sequence equals accepted input sequence.
REQ-025 SHALL ignore out_ready when out_valid=0 (no pointer or count change).

Reset
REQ-026 SHALL, on rising clk with rst=0, clear pointers, count=0, out_valid=0, full=0, overflow=0, drop_cnt=0.
REQ-027 SHALL, with rst=0, ignore wb_valid and out_ready that cycle; in-flight entries are discarded, not drained.
REQ-028 SHALL leave storage contents undefined after reset; out_reg/out_data/out_pc are don't-care while out_valid=0.

Configuration
REQ-029 SHALL, with macro WB_TRACE_ZERO_FILTER_EN defined, treat wb_valid with wb_reg=0 as no event (no push, no drop, no overflow).
REQ-030 SHALL, without WB_TRACE_ZERO_FILTER_EN, capture writes to register 0 like any other event.

Verification
REQ-031 SHALL cover: reset, one push reg=8 data=0x0000_0005 pc=0x0000_0004, out_ready=0 -> next cycle out_valid=1, count=1, fields match, stable 3 cycles.
REQ-032 SHALL cover: 8 pushes reg=1..8 with out_ready=0 -> full=1, count=8; then out_ready=1 -> reg 1..8 in order, one per cycle, then out_valid=0.
REQ-033 SHALL cover: full, push reg=9 with out_ready=0 for 3 cycles -> overflow=1, drop_cnt=3, count=8; FIFO contents unchanged.
REQ-034 SHALL cover: full, push and pop same cycle -> count stays 8, new entry emerges 8th; 20 continuous push+pop cycles exercise pointer wrap with order preserved.
REQ-035 SHALL cover: 4 entries queued, rst=0 one cycle with wb_valid=1 -> count=0, out_valid=0, overflow=0 next cycle.
REQ-036 SHALL cover: wb_valid=1 wb_reg=0 -> with WB_TRACE_ZERO_FILTER_EN count stays 0; without it count=1.
